// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and data access. Data wins
// ties, but a data-grant streak counter guarantees instruction fetch progress.
module mem_arbiter #(
  parameter int WORD_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              imemREN,
  input  logic [WORD_W-1:0] imemaddr,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic [WORD_W-1:0] dmemaddr,
  input  logic [WORD_W-1:0] dmemstore,
  input  logic [1:0]        ramstate,
  input  logic [WORD_W-1:0] ramload,
  output logic              iwait,
  output logic              dwait,
  output logic [WORD_W-1:0] iload,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

  localparam logic [1:0] RAM_FREE   = 2'd0;
  localparam logic [1:0] RAM_BUSY   = 2'd1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IREQ = 2'd1,
    DREQ = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [WORD_W-1:0] lat_addr_reg, lat_addr_next;
  logic [WORD_W-1:0] lat_store_reg, lat_store_next;
  logic              lat_wen_reg, lat_wen_next;
  logic [SW-1:0]     dstreak_reg, dstreak_next;

  logic dreq;
  logic ram_done;

  assign dreq     = dmemREN | dmemWEN;
  assign ram_done = (ramstate == RAM_ACCESS);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= IDLE;
      lat_addr_reg  <= '0;
      lat_store_reg <= '0;
      lat_wen_reg   <= 1'b0;
      dstreak_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      lat_addr_reg  <= lat_addr_next;
      lat_store_reg <= lat_store_next;
      lat_wen_reg   <= lat_wen_next;
      dstreak_reg   <= dstreak_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    lat_addr_next  = lat_addr_reg;
    lat_store_next = lat_store_reg;
    lat_wen_next   = lat_wen_reg;
    dstreak_next   = dstreak_reg;

    unique case (state_reg)
      IDLE: begin
        if (dreq && imemREN && (dstreak_reg == STREAK_MAX)) begin
          // Streak exhausted: the pending fetch takes this grant.
          state_next    = IREQ;
          lat_addr_next = imemaddr;
          dstreak_next  = '0;
        end else if (dreq) begin
          state_next     = DREQ;
          lat_addr_next  = dmemaddr;
          lat_store_next = dmemstore;
          lat_wen_next   = dmemWEN;
          if (!imemREN)
            dstreak_next = '0;
          else if (dstreak_reg != STREAK_MAX)
            dstreak_next = dstreak_reg + SW'(1);
        end else if (imemREN) begin
          state_next    = IREQ;
          lat_addr_next = imemaddr;
          dstreak_next  = '0;
        end
      end
      IREQ: begin
        // ACCESS outranks a simultaneous redirect: the fetch completed.
        if (ram_done)
          state_next = IDLE;
        else if (!imemREN || (imemaddr != lat_addr_reg))
          state_next = IDLE;
      end
      DREQ: begin
        if (ram_done)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ramREN = 1'b0;
    ramWEN = 1'b0;
    unique case (state_reg)
      IREQ:    ramREN = 1'b1;
      DREQ: begin
        ramREN = ~lat_wen_reg;
        ramWEN = lat_wen_reg;
      end
      default: ;
    endcase
  end

  assign ramaddr  = lat_addr_reg;
  assign ramstore = lat_store_reg;

  assign iwait = imemREN & ~((state_reg == IREQ) & ram_done);
  assign dwait = dreq & ~((state_reg == DREQ) & ram_done);

  assign iload = ramload;
  assign dload = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, fetch, data priority, starvation
// limit, fetch abort, unabortable data, and reset during a store.
module tb_mem_arbiter;

  localparam int W = 32;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2;

  logic          CLK = 1'b0;
  logic          RST;
  logic          imemREN, dmemREN, dmemWEN;
  logic [W-1:0]  imemaddr, dmemaddr, dmemstore, ramload;
  logic [1:0]    ramstate;
  logic          iwait, dwait, ramREN, ramWEN;
  logic [W-1:0]  iload, dload, ramaddr, ramstore;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.WORD_W(W), .STARVE_LIMIT(4)) dut (
    .CLK(CLK), .RST(RST),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .ramstate(ramstate), .ramload(ramload),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1; imemREN = 1'b1; imemaddr = 32'h40;
    dmemREN = 1'b0; dmemWEN = 1'b0; dmemaddr = '0; dmemstore = '0;
    ramstate = FREE; ramload = '0;

    // Reset held two cycles with a fetch pending
    tick(); tick(); #1;
    chk("rst_ramREN", ramREN, 0);
    chk("rst_ramWEN", ramWEN, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_ramstore", ramstore, 0);
    chk("rst_iwait", iwait, 1);
    RST = 1'b0;
    tick(); #1;
    chk("post_rst_ramREN", ramREN, 1);
    chk("post_rst_ramaddr", ramaddr, 32'h40);
    ramstate = ACCESS; ramload = 32'hCAFEF00D; #1;
    chk("post_rst_iwait", iwait, 0);
    tick(); imemREN = 1'b0; ramstate = FREE; #1;
    chk("post_rst_idle", ramREN, 0);

    // Instruction fetch at 0x100: 3 BUSY cycles then ACCESS
    imemREN = 1'b1; imemaddr = 32'h100; ramstate = BUSY; #1;
    chk("if_grant_cycle_ren", ramREN, 0);
    chk("if_grant_cycle_iwait", iwait, 1);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk($sformatf("if_busy%0d_ren", i), ramREN, 1);
      chk($sformatf("if_busy%0d_addr", i), ramaddr, 32'h100);
      chk($sformatf("if_busy%0d_iwait", i), iwait, 1);
    end
    ramstate = ACCESS; ramload = 32'hDEADBEEF; #1;
    chk("if_access_iwait", iwait, 0);
    chk("if_access_iload", iload, 32'hDEADBEEF);
    chk("if_access_dload", dload, 32'hDEADBEEF);
    tick(); ramstate = FREE; #1;
    chk("if_after_ren", ramREN, 0);
    chk("if_after_iwait", iwait, 1);
    imemREN = 1'b0;

    // Data priority: simultaneous fetch and store
    imemREN = 1'b1; imemaddr = 32'h300;
    dmemWEN = 1'b1; dmemaddr = 32'h200; dmemstore = 32'h1234; ramstate = BUSY; #1;
    chk("pri_grant_dwait", dwait, 1);
    tick(); #1;
    chk("pri_dreq_wen", ramWEN, 1);
    chk("pri_dreq_ren", ramREN, 0);
    chk("pri_dreq_addr", ramaddr, 32'h200);
    chk("pri_dreq_store", ramstore, 32'h1234);
    chk("pri_dreq_iwait", iwait, 1);
    ramstate = ACCESS; #1;
    chk("pri_access_dwait", dwait, 0);
    chk("pri_access_iwait", iwait, 1);
    tick(); dmemWEN = 1'b0; ramstate = FREE; #1;
    chk("pri_idle_wen", ramWEN, 0);
    chk("pri_idle_ren", ramREN, 0);
    tick(); #1;
    chk("pri_ireq_ren", ramREN, 1);
    chk("pri_ireq_addr", ramaddr, 32'h300);
    ramstate = ACCESS; #1;
    chk("pri_ireq_iwait", iwait, 0);
    tick(); imemREN = 1'b0; ramstate = FREE; #1;

    // Starvation: two rounds of 4 data grants then 1 fetch grant
    imemREN = 1'b1; imemaddr = 32'h400;
    dmemREN = 1'b1; dmemaddr = 32'h500; ramstate = ACCESS;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        tick(); #1;
        chk($sformatf("starve_r%0d_d%0d_addr", r, k), ramaddr, 32'h500);
        chk($sformatf("starve_r%0d_d%0d_ren", r, k), ramREN, 1);
        chk($sformatf("starve_r%0d_d%0d_dwait", r, k), dwait, 0);
        tick(); #1;
        chk($sformatf("starve_r%0d_d%0d_gap", r, k), ramREN, 0);
      end
      tick(); #1;
      chk($sformatf("starve_r%0d_i_addr", r), ramaddr, 32'h400);
      chk($sformatf("starve_r%0d_i_iwait", r), iwait, 0);
      chk($sformatf("starve_r%0d_i_dwait", r), dwait, 1);
      tick(); #1;
      chk($sformatf("starve_r%0d_i_gap", r), ramREN, 0);
    end
    imemREN = 1'b0; dmemREN = 1'b0; ramstate = FREE;
    tick(); #1;
    chk("starve_quiet", ramREN, 0);

    // Fetch abort on PC redirect while BUSY
    imemREN = 1'b1; imemaddr = 32'h100; ramstate = BUSY;
    tick(); #1;
    chk("abort_ireq_addr", ramaddr, 32'h100);
    imemaddr = 32'h180; #1;
    chk("abort_redirect_iwait", iwait, 1);
    chk("abort_redirect_ren", ramREN, 1);
    tick(); #1;
    chk("abort_idle_ren", ramREN, 0);
    chk("abort_idle_iwait", iwait, 1);
    tick(); #1;
    chk("abort_regrant_ren", ramREN, 1);
    chk("abort_regrant_addr", ramaddr, 32'h180);
    // ACCESS together with a redirect counts as completion
    imemaddr = 32'h1C0; ramstate = ACCESS; ramload = 32'h0BADF00D; #1;
    chk("abort_simul_iwait", iwait, 0);
    chk("abort_simul_iload", iload, 32'h0BADF00D);
    tick(); ramstate = BUSY; #1;
    chk("abort_simul_idle", ramREN, 0);
    // Fetch abort on imemREN dropping
    tick(); #1;
    chk("abort_ren_ireq_addr", ramaddr, 32'h1C0);
    imemREN = 1'b0;
    tick(); #1;
    chk("abort_ren_idle", ramREN, 0);

    // Data read is never aborted even if the request vanishes
    dmemREN = 1'b1; dmemaddr = 32'h700;
    tick(); #1;
    chk("dkeep_ren", ramREN, 1);
    dmemREN = 1'b0; dmemaddr = 32'h780; #1;
    chk("dkeep_dwait_gone", dwait, 0);
    tick(); #1;
    chk("dkeep_still_ren", ramREN, 1);
    chk("dkeep_still_addr", ramaddr, 32'h700);
    ramstate = ACCESS; ramload = 32'h5555AAAA; #1;
    chk("dkeep_dload", dload, 32'h5555AAAA);
    tick(); ramstate = FREE; #1;
    chk("dkeep_idle", ramREN, 0);

    // Reset in the middle of a BUSY store
    dmemWEN = 1'b1; dmemaddr = 32'h600; dmemstore = 32'hAA55; ramstate = BUSY;
    tick(); #1;
    chk("rststore_wen", ramWEN, 1);
    chk("rststore_store", ramstore, 32'hAA55);
    RST = 1'b1; #1;
    chk("rststore_dwait0", dwait, 1);
    tick(); #1;
    chk("rststore_wen_off", ramWEN, 0);
    chk("rststore_addr_clr", ramaddr, 0);
    chk("rststore_store_clr", ramstore, 0);
    chk("rststore_dwait1", dwait, 1);
    RST = 1'b0; ramstate = ACCESS; #1;
    chk("rststore_no_done", dwait, 1);
    dmemWEN = 1'b0;
    tick(); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single shared RAM port between the instruction-fetch requester and the data requester.
- Sits between the request block's enables (imemREN, dmemREN, dmemWEN) and the RAM interface; it generates the wait signals the request block and datapath use to derive ihit/dhit.
- Data has priority; a streak counter stops instruction fetch from being starved.
- One request is in flight at a time: it is latched at grant and held until RAM reports ACCESS.

Parameters:
- WORD_W, 32, width of address and data words.
- STARVE_LIMIT, 4, maximum consecutive data grants while an instruction fetch is pending; the next grant must go to instruction.

Ports:
- CLK  input  1  system clock, all state on rising edge
- RST  input  1  synchronous, active-high reset
- imemREN  input  1  instruction read request
- imemaddr  input  WORD_W  instruction address
- dmemREN  input  1  data read request
- dmemWEN  input  1  data write request (never asserted together with dmemREN)
- dmemaddr  input  WORD_W  data address
- dmemstore  input  WORD_W  store data
- ramstate  input  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
- ramload  input  WORD_W  RAM read data
- iwait  output  1  instruction request not yet satisfied
- dwait  output  1  data request not yet satisfied
- iload  output  WORD_W  instruction read data
- dload  output  WORD_W  data read data
- ramREN  output  1  RAM read enable
- ramWEN  output  1  RAM write enable
- ramaddr  output  WORD_W  RAM address
- ramstore  output  WORD_W  RAM write data

Behaviour:
- Interface: one clock, CLK; reset RST is synchronous and active-high.
- State machine states: IDLE, IREQ, DREQ.
- Registers: state, lat_addr, lat_store, lat_wen, dstreak (width clog2(STARVE_LIMIT+1)).
- Reset: state=IDLE, lat_* = 0, dstreak = 0.
  - This gives ramREN = ramWEN = 0 and ramaddr = ramstore = 0 on the cycle after RST is sampled high.
  - A reset asserted mid-transaction abandons the transaction with no completion pulse.
- Grant in IDLE, evaluated each cycle:
  - dreq = dmemREN | dmemWEN.
  - If dreq and imemREN are both high and dstreak == STARVE_LIMIT: go to IREQ and clear dstreak.
  - Else if dreq: go to DREQ. Latch dmemaddr, dmemstore, and lat_wen = dmemWEN. Increment dstreak (saturating) if imemREN is high, else clear it.
  - Else if imemREN: go to IREQ, latch imemaddr, clear dstreak.
  - Else: stay in IDLE.
- RAM drive:
  - IREQ: ramREN = 1, ramWEN = 0, ramaddr = lat_addr.
  - DREQ: ramREN = ~lat_wen, ramWEN = lat_wen, ramaddr = lat_addr, ramstore = lat_store.
  - IDLE: ramREN = ramWEN = 0.
  - ramaddr and ramstore always reflect the latched values. ramWEN and ramREN are never both high.
- Completion:
  - Complete happens in IREQ or DREQ when ramstate == ACCESS. Next state is IDLE.
  - BUSY, FREE and ERROR all hold the current state.
- Waits and load data (combinational):
  - iwait = imemREN & ~(state==IREQ & ramstate==ACCESS).
  - dwait = (dmemREN|dmemWEN) & ~(state==DREQ & ramstate==ACCESS).
  - iload = dload = ramload, both unregistered.
- Latency:
  - Minimum is 2 cycles from a request seen in IDLE to its wait dropping: the grant cycle, then the RAM cycle with ACCESS.
  - There is one mandatory IDLE cycle between transactions.
- Abort, IREQ only: if imemREN is low, or imemaddr != lat_addr (PC redirect), while not ACCESS, go to IDLE next cycle.
  - No completion is signalled.
  - The RAM enables drop the following cycle.
- DREQ is never aborted. A store that has been granted always completes.
- Simultaneous events: an ACCESS in the same cycle as an instruction address change counts as a completion, not an abort.
- New requests arriving during IREQ or DREQ are not sampled until IDLE.

Test Plan:
- Reset: hold RST 2 cycles with imemREN=1 -> ramREN=0, state IDLE; after release, ramREN=1 and ramaddr=imemaddr within 1 cycle.
- Instruction fetch: imemaddr=0x100, ramstate BUSY for 3 cycles then ACCESS, ramload=0xDEADBEEF -> iwait=1 until the ACCESS cycle, iwait=0 with iload=0xDEADBEEF for exactly that cycle, then IDLE.
- Data priority: imemREN=1 and dmemWEN=1 at the same time, dmemaddr=0x200, dmemstore=0x1234 -> DREQ first with ramWEN=1, ramaddr=0x200, ramstore=0x1234; after ACCESS, the next grant is IREQ.
- Starvation: imemREN held high with dmemREN requests back-to-back, ACCESS immediate -> exactly 4 data grants, then an instruction grant, then the streak restarts at 0.
- Instruction abort: in IREQ with addr 0x100, imemaddr changes to 0x180 while BUSY -> IDLE next cycle with no iwait drop; re-grant at 0x180.
- Reset mid-store: RST while in DREQ with BUSY -> IDLE and ramWEN=0 the next cycle, with dwait never deasserting.
